// File: rtl/quad_enc_sim_pkg.sv
// Shared constants for the simulated motor-feedback sources (quadrature and hall).
// Holds the AB state encoding and the direction constants.
package quad_enc_sim_pkg;

    typedef logic [1:0] ab_t;

    // AB outputs for each quadrature state, packed as {A, B}.
    localparam ab_t Q0_AB = 2'b00;
    localparam ab_t Q1_AB = 2'b10;
    localparam ab_t Q2_AB = 2'b11;
    localparam ab_t Q3_AB = 2'b01;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    function automatic ab_t q_to_ab(input logic [1:0] q);
        ab_t ab;
        case (q)
            2'd0:    ab = Q0_AB;
            2'd1:    ab = Q1_AB;
            2'd2:    ab = Q2_AB;
            default: ab = Q3_AB;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/enc_step_prescaler.sv
// Step prescaler: divides xclk down to one tick every max(step_period, 1) cycles.
// The partial count is discarded whenever enable is low.
module enc_step_prescaler #(
    parameter int PERIOD_W = 16
) (
    input  logic                xclk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] step_period,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;
    logic [PERIOD_W-1:0] last_cnt;

    // A >= compare lets a live shrink of step_period fire at once instead of
    // letting the counter run all the way around.
    assign last_cnt = (step_period == '0) ? '0 : step_period - PERIOD_W'(1);
    assign tick     = enable && (cnt_q >= last_cnt);

    always_comb begin
        cnt_d = cnt_q + PERIOD_W'(1);
        if (!enable || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/quad_enc_sim.sv
// Simulated quadrature encoder: registered, glitch-free A/B/I plus position.
// Define QUAD_ENC_SIM_INDEX_EN to build the position counter, enc_i and index_pulse.
module quad_enc_sim
    import quad_enc_sim_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int POS_W    = 16
) (
    input  logic                xclk,
    input  logic                reset,
    input  logic                enable,
    input  logic                direction,
    input  logic [PERIOD_W-1:0] step_period,
    input  logic [POS_W-1:0]    counts_per_rev,
    output logic                enc_a,
    output logic                enc_b,
    output logic                enc_i,
    output logic [POS_W-1:0]    position,
    output logic                index_pulse
);

    logic       tick;
    logic [1:0] q_q;
    logic [1:0] q_d;
    ab_t        ab_q;
    ab_t        ab_d;

    enc_step_prescaler #(
        .PERIOD_W (PERIOD_W)
    ) u_prescaler (
        .xclk        (xclk),
        .reset       (reset),
        .enable      (enable),
        .step_period (step_period),
        .tick        (tick)
    );

    // Stepping q by one in either direction guarantees a single A/B edge per tick,
    // and a reversal simply walks back through the state just left.
    always_comb begin
        q_d = q_q;
        if (tick) begin
            q_d = (direction == DIR_FWD) ? q_q + 2'd1 : q_q - 2'd1;
        end
        ab_d = q_to_ab(q_d);
    end

    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            q_q  <= 2'd0;
            ab_q <= Q0_AB;
        end else begin
            q_q  <= q_d;
            ab_q <= ab_d;
        end
    end

    assign enc_a = ab_q[1];
    assign enc_b = ab_q[0];

`ifdef QUAD_ENC_SIM_INDEX_EN
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;
    logic [POS_W-1:0] last_pos;
    logic             enc_i_q;
    logic             enc_i_d;
    logic             pulse_q;
    logic             pulse_d;

    // counts_per_rev of 0 underflows to all ones, i.e. a full 2^POS_W revolution.
    assign last_pos = counts_per_rev - POS_W'(1);

    // The forward wrap uses >= so that shrinking counts_per_rev below the
    // current position snaps back to 0 on the next forward step.
    always_comb begin
        pos_d   = pos_q;
        enc_i_d = enc_i_q;
        pulse_d = 1'b0;
        if (tick) begin
            if (direction == DIR_FWD) begin
                pos_d = (pos_q >= last_pos) ? '0 : pos_q + POS_W'(1);
            end else begin
                pos_d = (pos_q == '0) ? last_pos : pos_q - POS_W'(1);
            end
            enc_i_d = (pos_d == '0);
            pulse_d = (pos_d == '0) && (pos_q != '0);
        end
    end

    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            pos_q   <= '0;
            enc_i_q <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            enc_i_q <= enc_i_d;
            pulse_q <= pulse_d;
        end
    end

    assign position    = pos_q;
    assign enc_i       = enc_i_q;
    assign index_pulse = pulse_q;
`else
    logic unused_cpr;

    assign unused_cpr  = ^counts_per_rev;
    assign position    = '0;
    assign enc_i       = 1'b0;
    assign index_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_quad_enc_sim.sv
// Self-checking bench for quad_enc_sim: directed scenarios plus randomized stimulus
// against a step-counting reference model; honours QUAD_ENC_SIM_INDEX_EN.
module tb_quad_enc_sim;

`ifdef QUAD_ENC_SIM_INDEX_EN
    localparam bit IDX = 1'b1;
`else
    localparam bit IDX = 1'b0;
`endif

    logic        xclk;
    logic        reset;
    logic        enable;
    logic        direction;
    logic [15:0] step_period;
    logic [15:0] counts_per_rev;
    logic        enc_a;
    logic        enc_b;
    logic        enc_i;
    logic [15:0] position;
    logic        index_pulse;

    int checks = 0;
    int errors = 0;

    quad_enc_sim #(
        .PERIOD_W (16),
        .POS_W    (16)
    ) dut (
        .xclk           (xclk),
        .reset          (reset),
        .enable         (enable),
        .direction      (direction),
        .step_period    (step_period),
        .counts_per_rev (counts_per_rev),
        .enc_a          (enc_a),
        .enc_b          (enc_b),
        .enc_i          (enc_i),
        .position       (position),
        .index_pulse    (index_pulse)
    );

    initial xclk = 1'b0;
    always #5 xclk = ~xclk;

    // Reference model: a signed step count, a prescale count and an integer position.
    logic [1:0] abTable [4];
    int  mCnt;
    int  mSteps;
    int  mPos;
    bit  mIdx;
    bit  mPulse;

    initial begin
        abTable[0] = 2'b00;
        abTable[1] = 2'b10;
        abTable[2] = 2'b11;
        abTable[3] = 2'b01;
    end

    task automatic checkLit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [1:0] expAb;
        expAb = abTable[((mSteps % 4) + 4) % 4];
        checkLit("model_ab", {enc_a, enc_b}, expAb);
        checkLit("model_pos", position, IDX ? mPos : 0);
        checkLit("model_enc_i", enc_i, IDX ? mIdx : 0);
        checkLit("model_pulse", index_pulse, IDX ? mPulse : 0);
    endtask

    always @(posedge xclk) begin : model
        int  p;
        int  c;
        int  np;
        bit  tk;
        if (!reset) begin
            mCnt = 0; mSteps = 0; mPos = 0; mIdx = 1'b1; mPulse = 1'b0;
        end else begin
            p  = (step_period == 0) ? 1 : int'(step_period);
            tk = enable && (mCnt >= p - 1);
            mCnt = (!enable || tk) ? 0 : mCnt + 1;
            mPulse = 1'b0;
            if (tk) begin
                c = (counts_per_rev == 0) ? 65536 : int'(counts_per_rev);
                if (direction == 1'b0) begin
                    mSteps = mSteps + 1;
                    np = (mPos >= c - 1) ? 0 : mPos + 1;
                end else begin
                    mSteps = mSteps - 1;
                    np = (mPos == 0) ? c - 1 : mPos - 1;
                end
                mPulse = (np == 0) && (mPos != 0);
                mPos   = np;
                mIdx   = (mPos == 0);
            end
        end
        #1 checkOutput();
    end

    task automatic applyStimulus(input bit en, input bit dir, input int per, input int cpr);
        @(negedge xclk);
        enable         = en;
        direction      = dir;
        step_period    = 16'(per);
        counts_per_rev = 16'(cpr);
    endtask

    task automatic doReset();
        @(negedge xclk);
        reset  = 1'b0;
        enable = 1'b0;
        repeat (2) @(posedge xclk);
        @(negedge xclk);
        reset = 1'b1;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge xclk);
        #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] timeout");
    end

    initial begin : stim
        int pulses;
        reset = 1'b0; enable = 1'b0; direction = 1'b0;
        step_period = 16'd4; counts_per_rev = 16'd0;

        // Reset state
        waitEdges(3);
        checkLit("rst_ab", {enc_a, enc_b}, 0);
        checkLit("rst_pos", position, 0);
        checkLit("rst_enc_i", enc_i, IDX ? 1 : 0);
        checkLit("rst_pulse", index_pulse, 0);

        // Reset and run, P=4 forward
        @(negedge xclk); reset = 1'b1;
        applyStimulus(1, 0, 4, 0);
        waitEdges(3);
        checkLit("run_ab_c3", {enc_a, enc_b}, 2'b00);
        checkLit("run_enc_i_c3", enc_i, IDX ? 1 : 0);
        waitEdges(1);
        checkLit("run_ab_c4", {enc_a, enc_b}, 2'b10);
        checkLit("run_enc_i_c4", enc_i, 0);
        waitEdges(4);
        checkLit("run_ab_c8", {enc_a, enc_b}, 2'b11);
        waitEdges(4);
        checkLit("run_ab_c12", {enc_a, enc_b}, 2'b01);
        waitEdges(4);
        checkLit("run_ab_c16", {enc_a, enc_b}, 2'b00);

        // Reverse and wrap, C=8, P=1
        doReset();
        applyStimulus(1, 1, 1, 8);
        waitEdges(1);
        checkLit("rev_pos_1", position, IDX ? 7 : 0);
        checkLit("rev_ab_1", {enc_a, enc_b}, 2'b01);
        waitEdges(1);
        checkLit("rev_ab_2", {enc_a, enc_b}, 2'b11);
        waitEdges(6);
        checkLit("rev_pos_8", position, 0);
        checkLit("rev_pulse_8", index_pulse, IDX ? 1 : 0);
        checkLit("rev_ab_8", {enc_a, enc_b}, 2'b00);
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            waitEdges(1);
            if (index_pulse) pulses++;
        end
        checkLit("rev_pulse_count", pulses, IDX ? 3 : 0);

        // Mid-run reversal, P=2
        doReset();
        applyStimulus(1, 0, 2, 100);
        waitEdges(6);
        checkLit("mid_pos_3", position, IDX ? 3 : 0);
        checkLit("mid_ab_3", {enc_a, enc_b}, 2'b01);
        applyStimulus(1, 1, 2, 100);
        waitEdges(2);
        checkLit("mid_ab_rev1", {enc_a, enc_b}, 2'b11);
        checkLit("mid_pos_rev1", position, IDX ? 2 : 0);
        waitEdges(2);
        checkLit("mid_ab_rev2", {enc_a, enc_b}, 2'b10);
        checkLit("mid_pos_rev2", position, IDX ? 1 : 0);

        // Live period shrink and disable
        doReset();
        applyStimulus(1, 0, 100, 0);
        waitEdges(50);
        checkLit("shrink_ab_before", {enc_a, enc_b}, 2'b00);
        applyStimulus(1, 0, 10, 0);
        waitEdges(1);
        checkLit("shrink_ab_next", {enc_a, enc_b}, 2'b10);
        waitEdges(5);
        applyStimulus(0, 0, 10, 0);
        waitEdges(3);
        applyStimulus(1, 0, 10, 0);
        waitEdges(9);
        checkLit("reenable_ab_c9", {enc_a, enc_b}, 2'b10);
        waitEdges(1);
        checkLit("reenable_ab_c10", {enc_a, enc_b}, 2'b11);

        // Edge values: P=0, C=0 wrap, live C reduction
        doReset();
        applyStimulus(1, 1, 0, 0);
        waitEdges(1);
        checkLit("p0_ab", {enc_a, enc_b}, 2'b01);
        checkLit("c0_pos_max", position, IDX ? 65535 : 0);
        applyStimulus(1, 0, 0, 0);
        waitEdges(1);
        checkLit("c0_pos_wrap", position, 0);
        checkLit("c0_pulse", index_pulse, IDX ? 1 : 0);
        doReset();
        applyStimulus(1, 0, 0, 100);
        waitEdges(50);
        checkLit("cred_pos_50", position, IDX ? 50 : 0);
        applyStimulus(1, 0, 0, 10);
        waitEdges(1);
        checkLit("cred_fwd_pos", position, 0);
        checkLit("cred_fwd_pulse", index_pulse, IDX ? 1 : 0);
        doReset();
        applyStimulus(1, 0, 0, 100);
        waitEdges(50);
        applyStimulus(1, 1, 0, 10);
        waitEdges(1);
        checkLit("cred_rev_pos", position, IDX ? 49 : 0);

        // Randomized run against the model
        doReset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge xclk);
            reset = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            if ($urandom_range(0, 9) == 0) direction = $urandom_range(0, 1);
            if ($urandom_range(0, 29) == 0) step_period = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 39) == 0) counts_per_rev = 16'($urandom_range(0, 12));
        end
        @(negedge xclk);
        reset = 1'b1;
        waitEdges(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_enc_sim.md
# quad_enc_sim

- Simulated quadrature encoder source: generates phase A, phase B and index I from a programmable step period, direction and counts-per-revolution.
- Two instances (channel 1 and channel 2) feed the ENC_A1/B1/I1 and ENC_A2/B2/I2 inputs of the digital-output function-select muxes.
- Step period, direction, enable and counts-per-rev come from host-written registers.
- Outputs are registered and glitch-free, so any mux path carries clean edges.

## Interface
Parameters:
- PERIOD_W, 16, width of step_period and of the prescaler counter
- POS_W, 16, width of counts_per_rev and position

Ports:
- xclk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run when high; freeze when low
- direction  in  1  0 = forward (A leads B), 1 = reverse (B leads A)
- step_period  in  PERIOD_W  xclk cycles per quadrature state; 0 is treated as 1
- counts_per_rev  in  POS_W  quadrature states per revolution; 0 is treated as 2^POS_W
- enc_a  out  1  phase A
- enc_b  out  1  phase B
- enc_i  out  1  index: high for the one quadrature state where position == 0
- position  out  POS_W  current count, 0..counts_per_rev-1
- index_pulse  out  1  one-cycle strobe on the cycle position becomes 0

## Operation
- Prescaler:
  - Counts 0..P-1, where P = max(step_period, 1).
  - `tick` = enable && (cnt == P-1); on tick, cnt returns to 0.
  - enable low: cnt held at 0, no ticks.
- Quadrature state q (2 bits), with AB sequence q0=00, q1=10, q2=11, q3=01:
  - On tick, forward: q ← q+1 mod 4. Reverse: q ← q−1 mod 4.
  - enc_a/enc_b are registered from the next q, so they change on the tick edge.
  - Exactly one of A/B changes per tick.
- Position:
  - On tick, forward: position ← (position == C−1) ? 0 : position+1, where C = counts_per_rev (0 ⇒ 2^POS_W).
  - On tick, reverse: position ← (position == 0) ? C−1 : position−1.
  - enc_i ← (next position == 0), updated with position.
  - index_pulse is high for one cycle when a tick moves position to 0 from a nonzero value.
- direction and counts_per_rev are sampled only on tick.
  - A reversal takes effect on the next tick without skipping or repeating an AB state.
- Live step_period change: if cnt ≥ new P−1, the tick fires on the next cycle (compare is ≥, not ==).
- Live counts_per_rev change to a value ≤ position: the next forward tick wraps to 0; the next reverse tick decrements normally.
- Reset values: enc_a=0, enc_b=0, q=0, cnt=0, position=0, enc_i=1, index_pulse=0.
- Reset assertion mid-run: all state returns to reset values immediately.

## Timing
- The first tick occurs P cycles after enable is first sampled high.
- Subsequent ticks occur every P cycles.
- Output A frequency = f_xclk / (4·P); duty 50 %; A/B phase 90°.
- Output latency: outputs change on the same edge that consumes the tick (zero added cycles).
- P=1: one AB state per clock; A toggles every 2 clocks.
- enable dropped between ticks: partial prescale count is discarded. On re-enable, the first tick occurs after a full P cycles.

## Configuration
- `QUAD_ENC_SIM_INDEX_EN` defined:
  - Position counter, counts_per_rev handling, enc_i and index_pulse are built as above.
- Not defined:
  - The position logic is not synthesized.
  - enc_i, index_pulse and position are tied to 0.
  - counts_per_rev is ignored.
  - A/B behaviour is unchanged.

## Structure
- Shared package holds the AB state encoding constants (Q0_AB..Q3_AB) and the DIR_FWD/DIR_REV constants.
- The package is also used by the hall simulator.
- One sub-module: `enc_step_prescaler`, which owns the prescaler counter, the ≥ compare and the enable clear, and outputs `tick`.
- Quadrature and position logic stay in the top.

## Test plan
- Reset and run: reset low, then high; enable=1, step_period=4, dir=0.
  - A rises at cycle 4, B at 8, A falls at 12, B at 16.
  - enc_i=1 until the first tick.
- Reverse and wrap: counts_per_rev=8, dir=1, P=1 from reset.
  - Position goes 7,6,…,0.
  - AB sequence goes 01,11,10,00.
  - index_pulse fires once per 8 ticks, on entry to 0.
- Mid-run reversal: P=2, forward to position 3 (AB=01), then dir=1.
  - Next states are AB=11 at position 2, then AB=10 at position 1.
  - No AB state is skipped.
- Live period shrink and disable: P=100 with cnt=50, write P=10.
  - Tick fires the next cycle.
  - enable=0 at cnt=5, then re-enable: next tick occurs 10 cycles later.
- Edge values: step_period=0 gives a tick every cycle.
  - counts_per_rev=0 gives the wrap 65535→0 with index_pulse.
  - Reducing counts_per_rev from 100 to 10 at position 50 gives the next forward position 0.
- Macro off: same stimulus as the first case gives identical A/B; enc_i, index_pulse and position stay 0.
